// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: synchronizes reset deassertion, holds the downstream
// reset for a settling period, then counts run cycles until a limit or stop request.
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             stop_req,
  output logic             rst_sync_n,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SYNC_STAGES-2:0] SYNC_ONE = 1;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-2:0] sync_chain;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]       limit_q, limit_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       count_inc;
  logic                   rst_n_q, rst_n_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;

  // The state register acts as the last synchronizer stage, so the explicit
  // chain is one flop shorter than SYNC_STAGES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain  <= '0;
      state_q     <= ST_SYNC;
      hold_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      limit_q     <= '0;
      count_q     <= '0;
      rst_n_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sync_chain  <= (sync_chain << 1) | SYNC_ONE;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stop_pend_q <= stop_pend_d;
      limit_q     <= limit_d;
      count_q     <= count_d;
      rst_n_q     <= rst_n_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stop_pend_d = stop_pend_q;
    limit_d     = limit_q;
    count_d     = count_q;
    rst_n_d     = rst_n_q;
    running_d   = running_q;
    done_d      = done_q;
    case (state_q)
      ST_SYNC: begin
        if (stop_req) begin
          stop_pend_d = 1'b1;
        end
        if (sync_chain[SYNC_STAGES-2]) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          limit_d = run_cycles;
          rst_n_d = 1'b1;
          // A stop seen at any point before release skips RUN entirely.
          if (stop_pend_q || stop_req) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_RUN;
            running_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (stop_req) begin
            stop_pend_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d   = ST_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
        end else if (count_q != '1) begin
          count_d = count_inc;
          if ((limit_q != '0) && (count_inc == limit_q)) begin
            state_d   = ST_DONE;
            running_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign rst_sync_n  = rst_n_q;
  assign running     = running_q;
  assign done        = done_q;
  assign cycle_count = count_q;
  assign state       = state_q;

endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
- Consumer-side counterpart to the bench clock/reset generator.
- Takes the free-running clock and an asynchronous active-high reset, synchronizes reset release, and holds a downstream active-low reset for a fixed settling period.
- Then counts run cycles and raises a sticky done/stop indication at a programmed cycle limit or on an external stop request.
- Sits between the clock/reset source and DUT logic; its outputs drive the DUT reset and the bench end-of-run control.

Parameters:
- SYNC_STAGES, 2, depth of the reset-release synchronizer chain (>=2).
- HOLD_CYCLES, 4, extra cycles rst_sync_n is held low after synchronization (>=1).
- CNT_W, 32, width of the run-cycle counter and the limit input.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset. Assertion is asynchronous; deassertion is synchronized internally.
- run_cycles  input  CNT_W  run-length limit; 0 = unlimited.
- stop_req  input  1  synchronous request to end the run.
- rst_sync_n  output  1  downstream active-low reset, released synchronously.
- running  output  1  high while in RUN.
- done  output  1  sticky end-of-run flag.
- cycle_count  output  CNT_W  cycles elapsed in RUN.
- state  output  2  SYNC=0, HOLD=1, RUN=2, DONE=3.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- While reset=1, all registers clear immediately with no clock needed:
  - synchronizer chain = 0, state = SYNC, rst_sync_n = 0, running = 0, done = 0, cycle_count = 0.
  - hold counter and stop-pending latch = 0.
  - A reset pulse shorter than one clock period still clears fully.
- Edge numbering: edge n = the n-th rising clk edge after reset deasserts. Let E = SYNC_STAGES + HOLD_CYCLES (6 at defaults).
- SYNC: a 1 shifts through the chain. After edge SYNC_STAGES the state is HOLD.
- HOLD: the hold counter counts HOLD_CYCLES edges. At edge E:
  - state becomes RUN, rst_sync_n = 1, running = 1.
  - run_cycles is captured into a limit register. Later changes to run_cycles are ignored until the next reset.
- RUN:
  - Each edge increments cycle_count, so after edge E+k, cycle_count = k.
  - If the limit is nonzero and the increment makes cycle_count equal the limit: state becomes DONE on that same edge, running = 0, done = 1.
  - If stop_req = 1 at an edge in RUN: state becomes DONE on that edge and cycle_count does not increment on that edge. stop_req has priority over the increment.
  - Limit 0: the counter saturates at all-ones (no wrap). running stays 1 and done stays 0.
- stop_req = 1 at any edge in SYNC or HOLD sets the stop-pending latch. At edge E the state goes directly to DONE: rst_sync_n = 1, running = 0, done = 1, cycle_count = 0.
- DONE:
  - Terminal state until reset.
  - cycle_count and done hold; rst_sync_n stays 1.
  - stop_req and run_cycles are ignored.
- rst_sync_n, running and done are registered outputs (no combinational paths from inputs).
- Reset asserted mid-operation in any state aborts immediately and the full sequence restarts after release.
- reset has priority over all synchronous events, including a coincident stop_req or limit match.

Test Plan:
- Defaults, reset high 3 cycles, run_cycles = 10 -> rst_sync_n = 0 through edge 5 and 1 after edge 6; state 0→1 at edge 2, →2 at edge 6; cycle_count = 10, done = 1, running = 0, state = 3 after edge 16; all values hold through edge 30.
- CNT_W = 4, run_cycles = 0 -> cycle_count = 15 after edge 21; stays 15 through edge 40; running = 1, done = 0.
- run_cycles = 10, stop_req high for one cycle at edge 9 -> DONE after edge 9 with cycle_count = 2 (stop edge does not count); done = 1, rst_sync_n = 1.
- stop_req pulse at edge 4 (HOLD) -> state 1 until edge 6, then 3; rst_sync_n = 1, done = 1, cycle_count = 0, running never 1.
- Reset asserted mid-run at cycle_count = 5, between clock edges -> rst_sync_n = 0, state = 0, cycle_count = 0 immediately; after release, rst_sync_n returns to 1 exactly after edge 6.
- run_cycles = 10 captured, then changed to 3 when cycle_count = 5 -> change ignored; done rises after edge 16 with cycle_count = 10.
